// File: rtl/traffic_light_if.sv
// Signal bundle between the intersection sequencer and its surroundings
// (tick source, push-button, night switch, lamp drivers, countdown display).
interface traffic_light_if;
  logic       sec_tick;
  logic       ped_req;
  logic       night_mode;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [6:0] remaining;
  logic [2:0] phase;

  modport master (
    output sec_tick, ped_req, night_mode,
    input  ns_light, ew_light, remaining, phase
  );

  modport slave (
    input  sec_tick, ped_req, night_mode,
    output ns_light, ew_light, remaining, phase
  );
endinterface

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer with per-phase down-counter, pedestrian
// green shortening and night flashing-yellow mode.
module traffic_light_controller #(
  parameter int unsigned pGREEN_NS = 30,
  parameter int unsigned pGREEN_EW = 25,
  parameter int unsigned pYELLOW   = 3,
  parameter int unsigned pALL_RED  = 2,
  parameter int unsigned pPED_MIN  = 5
) (
  input  logic            clk,
  input  logic            rst,
  traffic_light_if.slave  tl
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } phase_e;

  localparam logic [6:0] LD_NS_G = 7'(pGREEN_NS - 1);
  localparam logic [6:0] LD_EW_G = 7'(pGREEN_EW - 1);
  localparam logic [6:0] LD_Y    = 7'(pYELLOW - 1);
  localparam logic [6:0] LD_AR   = 7'(pALL_RED - 1);
  localparam logic [6:0] LD_PED  = 7'(pPED_MIN - 1);

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;

  phase_e     phase_q, phase_d;
  logic [6:0] rem_q, rem_d;
  logic       ped_pending_q, ped_pending_d;
  logic       flash_ph_q, flash_ph_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;

  function automatic phase_e next_of(input phase_e p);
    case (p)
      NS_G:    next_of = NS_Y;
      NS_Y:    next_of = AR1;
      AR1:     next_of = EW_G;
      EW_G:    next_of = EW_Y;
      EW_Y:    next_of = AR2;
      default: next_of = NS_G;
    endcase
  endfunction

  function automatic logic [6:0] load_of(input phase_e p);
    case (p)
      NS_G:       load_of = LD_NS_G;
      EW_G:       load_of = LD_EW_G;
      NS_Y, EW_Y: load_of = LD_Y;
      AR1, AR2:   load_of = LD_AR;
      default:    load_of = '0;
    endcase
  endfunction

  always_comb begin
    phase_d       = phase_q;
    rem_d         = rem_q;
    flash_ph_d    = flash_ph_q;
    ped_pending_d = ped_pending_q | tl.ped_req;
    if (phase_q == FLASH) ped_pending_d = 1'b0;

    if (3'(phase_q) == 3'd7) begin
      phase_d    = AR2;
      rem_d      = LD_AR;
      flash_ph_d = 1'b0;
    end else if (tl.sec_tick) begin
      // Night mode outranks both the phase-end and the pedestrian rules.
      if (tl.night_mode && phase_q != FLASH) begin
        phase_d       = FLASH;
        rem_d         = '0;
        flash_ph_d    = 1'b1;
        ped_pending_d = 1'b0;
      end else if (phase_q == FLASH) begin
        if (tl.night_mode) begin
          flash_ph_d = ~flash_ph_q;
        end else begin
          phase_d    = AR2;
          rem_d      = LD_AR;
          flash_ph_d = 1'b0;
        end
      end else if (rem_q == '0) begin
        phase_d = next_of(phase_q);
        rem_d   = load_of(next_of(phase_q));
        if (next_of(phase_q) == AR1 || next_of(phase_q) == AR2)
          ped_pending_d = tl.ped_req;
      end else if ((phase_q == NS_G || phase_q == EW_G) && ped_pending_q
                   && rem_q > LD_PED) begin
        rem_d = LD_PED;
      end else begin
        rem_d = rem_q - 7'd1;
      end
    end

    case (phase_d)
      NS_G:    begin ns_light_d = LAMP_G; ew_light_d = LAMP_R; end
      NS_Y:    begin ns_light_d = LAMP_Y; ew_light_d = LAMP_R; end
      EW_G:    begin ns_light_d = LAMP_R; ew_light_d = LAMP_G; end
      EW_Y:    begin ns_light_d = LAMP_R; ew_light_d = LAMP_Y; end
      FLASH:   begin
        ns_light_d = {1'b0, flash_ph_d, 1'b0};
        ew_light_d = {1'b0, flash_ph_d, 1'b0};
      end
      default: begin ns_light_d = LAMP_R; ew_light_d = LAMP_R; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= NS_G;
      rem_q         <= LD_NS_G;
      ped_pending_q <= 1'b0;
      flash_ph_q    <= 1'b0;
      ns_light_q    <= LAMP_G;
      ew_light_q    <= LAMP_R;
    end else begin
      phase_q       <= phase_d;
      rem_q         <= rem_d;
      ped_pending_q <= ped_pending_d;
      flash_ph_q    <= flash_ph_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
    end
  end

  assign tl.ns_light  = ns_light_q;
  assign tl.ew_light  = ew_light_q;
  assign tl.remaining = rem_q;
  assign tl.phase     = 3'(phase_q);

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller: vector table, directed
// corner sequences and random stimulus against a rule-level reference model.
module tb_traffic_light_controller;

  localparam int PED_MIN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_if tl ();

  traffic_light_controller #(
    .pGREEN_NS (30),
    .pGREEN_EW (25),
    .pYELLOW   (3),
    .pALL_RED  (2),
    .pPED_MIN  (PED_MIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tl  (tl)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase index 0..5 in sequence order, 6 = flashing.
  int dur[6]          = '{30, 3, 2, 25, 3, 2};
  bit [2:0] ns_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  bit [2:0] ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_ph   = 0;
  int m_rem  = 29;
  bit m_pend = 0;
  bit m_fl   = 0;

  task automatic model_update(input bit t, input bit p, input bit n, input bit r);
    bit np;
    if (r) begin
      m_ph = 0; m_rem = dur[0] - 1; m_pend = 0; m_fl = 0;
      return;
    end
    np = m_pend | p;
    if (m_ph == 6) np = 0;
    if (t) begin
      if (n && m_ph != 6) begin
        m_ph = 6; m_rem = 0; m_fl = 1; np = 0;
      end else if (m_ph == 6) begin
        if (n) m_fl = !m_fl;
        else begin m_ph = 5; m_rem = dur[5] - 1; m_fl = 0; end
      end else if (m_rem == 0) begin
        m_ph  = (m_ph + 1) % 6;
        m_rem = dur[m_ph] - 1;
        if (m_ph == 2 || m_ph == 5) np = p;
      end else if ((m_ph == 0 || m_ph == 3) && m_pend && m_rem > PED_MIN - 1) begin
        m_rem = PED_MIN - 1;
      end else begin
        m_rem = m_rem - 1;
      end
    end
    m_pend = np;
  endtask

  task automatic drive(input bit t, input bit p, input bit n, input bit r);
    @(negedge clk);
    tl.sec_tick = t; tl.ped_req = p; tl.night_mode = n; rst = r;
    @(posedge clk);
    #1;
    model_update(t, p, n, r);
  endtask

  task automatic chk(input string name, input logic [2:0] ph, input logic [6:0] rem,
                     input logic [2:0] ns, input logic [2:0] ew);
    checks++;
    if (tl.phase !== ph || tl.remaining !== rem || tl.ns_light !== ns || tl.ew_light !== ew) begin
      errors++;
      $display("FAIL %s: phase/rem/ns/ew got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
               name, tl.phase, tl.remaining, tl.ns_light, tl.ew_light, ph, rem, ns, ew);
    end
  endtask

  task automatic chk_pr(input string name, input logic [2:0] ph, input logic [6:0] rem);
    checks++;
    if (tl.phase !== ph || tl.remaining !== rem) begin
      errors++;
      $display("FAIL %s: phase/rem got %0d/%0d want %0d/%0d",
               name, tl.phase, tl.remaining, ph, rem);
    end
  endtask

  task automatic step(input bit t, input bit p, input bit n, input bit r);
    bit [2:0] ens, eew;
    drive(t, p, n, r);
    ens = (m_ph == 6) ? {1'b0, m_fl, 1'b0} : ns_tab[m_ph];
    eew = (m_ph == 6) ? {1'b0, m_fl, 1'b0} : ew_tab[m_ph];
    chk("model", 3'(m_ph), 7'(m_rem), ens, eew);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit         tick, ped, night, rst;
    logic [2:0] ph;
    logic [6:0] rem;
    logic [2:0] ns, ew;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 7'd29, 3'b001, 3'b100};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd28, 3'b001, 3'b100};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd28, 3'b001, 3'b100};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd4,  3'b001, 3'b100};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd3,  3'b001, 3'b100};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 7'd0,  3'b010, 3'b010};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 7'd0,  3'b000, 3'b000};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 7'd1,  3'b100, 3'b100};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 7'd0,  3'b100, 3'b100};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd29, 3'b001, 3'b100};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd28, 3'b001, 3'b100};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 7'd29, 3'b001, 3'b100};

    tl.sec_tick = 1'b0; tl.ped_req = 1'b0; tl.night_mode = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].tick, vecs[i].ped, vecs[i].night, vecs[i].rst);
      chk($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rem, vecs[i].ns, vecs[i].ew);
    end

    // Full cycle from reset
    step(0, 0, 0, 1);
    chk("reset", 3'd0, 7'd29, 3'b001, 3'b100);
    ticks(30); chk("ns_y_entry", 3'd1, 7'd2, 3'b010, 3'b100);
    ticks(3);  chk("ar1_entry", 3'd2, 7'd1, 3'b100, 3'b100);
    ticks(2);  chk("ew_g_entry", 3'd3, 7'd24, 3'b100, 3'b001);
    ticks(25); chk("ew_y_entry", 3'd4, 7'd2, 3'b100, 3'b010);
    ticks(3);  chk("ar2_entry", 3'd5, 7'd1, 3'b100, 3'b100);
    ticks(2);  chk("wrap_ns_g", 3'd0, 7'd29, 3'b001, 3'b100);

    // Ped shortening in NS_G, then cleared at AR1
    step(0, 0, 0, 1);
    ticks(9); chk_pr("ped_rem20", 3'd0, 7'd20);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); chk_pr("ped_short", 3'd0, 7'd4);
    ticks(4); chk_pr("ped_rem0", 3'd0, 7'd0);
    step(1, 0, 0, 0); chk_pr("ped_ns_y", 3'd1, 7'd2);
    ticks(5); chk_pr("ped_ew_g", 3'd3, 7'd24);
    step(1, 0, 0, 0); chk_pr("ped_cleared", 3'd3, 7'd23);

    // Ped request late in green does not extend it
    step(0, 0, 0, 1);
    ticks(56); chk_pr("late_rem3", 3'd3, 7'd3);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); chk_pr("late_2", 3'd3, 7'd2);
    step(1, 0, 0, 0); chk_pr("late_1", 3'd3, 7'd1);
    step(1, 0, 0, 0); chk_pr("late_0", 3'd3, 7'd0);
    step(1, 0, 0, 0); chk_pr("late_ew_y", 3'd4, 7'd2);

    // Ped request on the AR1-entry cycle survives into EW_G
    step(0, 0, 0, 1);
    ticks(32); chk_pr("ny_rem0", 3'd1, 7'd0);
    step(1, 1, 0, 0); chk_pr("ar1_set_wins", 3'd2, 7'd1);
    ticks(2); chk_pr("ew_g_kept", 3'd3, 7'd24);
    step(1, 0, 0, 0); chk_pr("ew_g_short", 3'd3, 7'd4);

    // Night mode from EW_G
    step(0, 0, 0, 1);
    ticks(49); chk_pr("night_ew10", 3'd3, 7'd10);
    step(1, 0, 1, 0); chk("flash_on", 3'd6, 7'd0, 3'b010, 3'b010);
    step(1, 0, 1, 0); chk("flash_off", 3'd6, 7'd0, 3'b000, 3'b000);
    step(1, 1, 1, 0); chk("flash_on2", 3'd6, 7'd0, 3'b010, 3'b010);
    step(1, 0, 0, 0); chk("flash_exit", 3'd5, 7'd1, 3'b100, 3'b100);
    step(1, 0, 0, 0); chk("flash_ar2_0", 3'd5, 7'd0, 3'b100, 3'b100);
    step(1, 0, 0, 0); chk("flash_ns_g", 3'd0, 7'd29, 3'b001, 3'b100);
    step(1, 0, 0, 0); chk_pr("flash_no_ped", 3'd0, 7'd28);

    // Reset mid EW_Y with pending request
    step(0, 0, 0, 1);
    ticks(60); chk_pr("rst_ew_y", 3'd4, 7'd2);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1); chk("rst_mid", 3'd0, 7'd29, 3'b001, 3'b100);
    step(1, 0, 0, 0); chk_pr("rst_pend_clr", 3'd0, 7'd28);

    // No ticks for 200 clocks
    step(0, 0, 0, 1);
    for (int i = 0; i < 200; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b0);
    chk("hold", 3'd0, 7'd29, 3'b001, 3'b100);
    step(1, 0, 0, 0); chk_pr("hold_pend", 3'd0, 7'd4);

    // Random stimulus against the model
    begin
      bit night = 0;
      step(0, 0, 0, 1);
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 59) == 0) night = !night;
        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
             night, 1'($urandom_range(0, 999) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
